difftest_commit_serializer: RTL and testbench

Sits between the commit stage and the difftest commit-record sink, under ENABLE_DIFFTEST. Each cycle it accepts a commit group of up to CW=2^CONFIG_P_COMMIT_WIDTH retiring instructions and buffers the group in a group FIFO. It emits the instructions one record per cycle in program order over a valid/ready handshake, and numbers each record with a running sequence count. It raises a stall request to the commit stage before the buffer can overflow.

---
 rtl/difftest_commit_serializer_pkg.sv | 16 +
 rtl/difftest_group_fifo.sv | 62 ++++++
 rtl/difftest_commit_serializer.sv | 206 ++++++++++++++++++++
 tb/tb_difftest_commit_serializer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_commit_serializer_pkg.sv
// Shared widths for the difftest commit serializer: core field widths and
// the packed width of one buffered commit group.
package difftest_commit_serializer_pkg;

  localparam int PC_W         = 30;
  localparam int NCPU_INSN_DW = 32;
  localparam int NCPU_LRF_AW  = 5;
  localparam int EXCP_VECT_W  = 32;
  localparam int SEQ_W        = 32;

  // Packed group layout: {fire, pc, insn, wen, wnum, wdata, excp, excp_vect, irqc_irr}
  function automatic int group_width(input int cw, input int dw, input int nirq);
    return cw * (1 + PC_W + NCPU_INSN_DW + 1 + NCPU_LRF_AW + dw) + 1 + EXCP_VECT_W + nirq;
  endfunction

endpackage

// File: rtl/difftest_group_fifo.sv
// Synchronous FIFO holding whole commit groups. Pointers carry a wrap bit;
// a push while full is dropped even if a pop happens in the same cycle.
module difftest_group_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r == {~rd_ptr_r[AW], rd_ptr_r[AW-1:0]});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];
  assign count     = count_r;

  // Group storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + {{AW{1'b0}}, 1'b1};
      end else if (pop_ok_s && !push_ok_s) begin
        count_r <= count_r - {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/difftest_commit_serializer.sv
// Buffers commit groups and replays them to the difftest sink one record per
// cycle in program order, numbering instruction records with a running count.
module difftest_commit_serializer
  import difftest_commit_serializer_pkg::*;
#(
  parameter int CONFIG_DW             = 32,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_NUM_IRQ        = 32,
  parameter int CONFIG_P_FIFO_DEPTH   = 3,
  parameter int STALL_MARGIN          = 2,
  localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CW-1:0]                in_fire,
  input  logic [PC_W*CW-1:0]           in_pc,
  input  logic [NCPU_INSN_DW*CW-1:0]   in_insn,
  input  logic [CW-1:0]                in_wen,
  input  logic [NCPU_LRF_AW*CW-1:0]    in_wnum,
  input  logic [CONFIG_DW*CW-1:0]      in_wdata,
  input  logic                         in_excp,
  input  logic [EXCP_VECT_W-1:0]       in_excp_vect,
  input  logic [CONFIG_NUM_IRQ-1:0]    in_irqc_irr,
  output logic                         cmt_stall,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_insn_valid,
  output logic [PC_W-1:0]              out_pc,
  output logic [NCPU_INSN_DW-1:0]      out_insn,
  output logic                         out_wen,
  output logic [NCPU_LRF_AW-1:0]       out_wnum,
  output logic [CONFIG_DW-1:0]         out_wdata,
  output logic                         out_excp,
  output logic [EXCP_VECT_W-1:0]       out_excp_vect,
  output logic [CONFIG_NUM_IRQ-1:0]    out_irqc_irr,
  output logic [SEQ_W-1:0]             out_seq,
  output logic                         ovf_err
);

  localparam int AW = CONFIG_P_FIFO_DEPTH;
  localparam int FD = 1 << AW;
  localparam int SW = (CONFIG_P_COMMIT_WIDTH > 0) ? CONFIG_P_COMMIT_WIDTH : 1;
  localparam int GW = group_width(CW, CONFIG_DW, CONFIG_NUM_IRQ);

  logic [GW-1:0]                grp_in_s;
  logic [GW-1:0]                grp_head_s;
  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic [AW:0]                  fifo_count_s;
  logic [AW:0]                  count_next_s;
  logic [AW:0]                  free_next_s;
  logic                         push_req_s;
  logic                         push_ok_s;
  logic                         xfer_s;
  logic                         pop_s;

  logic [CW-1:0]                h_fire_s;
  logic [PC_W*CW-1:0]           h_pc_s;
  logic [NCPU_INSN_DW*CW-1:0]   h_insn_s;
  logic [CW-1:0]                h_wen_s;
  logic [NCPU_LRF_AW*CW-1:0]    h_wnum_s;
  logic [CONFIG_DW*CW-1:0]      h_wdata_s;
  logic                         h_excp_s;
  logic [EXCP_VECT_W-1:0]       h_vect_s;
  logic [CONFIG_NUM_IRQ-1:0]    h_irr_s;

  logic [CW-1:0]                mask_r;
  logic                         first_r;
  logic [CW-1:0]                eff_mask_s;
  logic [CW-1:0]                sel_onehot_s;
  logic [CW-1:0]                remain_s;
  logic [SW-1:0]                sel_idx_s;
  logic                         insn_valid_s;
  logic                         last_s;
  logic [SEQ_W-1:0]             seq_r;
  logic                         stall_r;
  logic                         ovf_r;

  assign grp_in_s = {in_fire, in_pc, in_insn, in_wen, in_wnum, in_wdata,
                     in_excp, in_excp_vect, in_irqc_irr};
  assign {h_fire_s, h_pc_s, h_insn_s, h_wen_s, h_wnum_s, h_wdata_s,
          h_excp_s, h_vect_s, h_irr_s} = grp_head_s;

  assign push_req_s = (|in_fire) | in_excp;
  assign push_ok_s  = push_req_s & ~fifo_full_s;
  assign out_valid  = ~fifo_empty_s;
  assign xfer_s     = out_valid & out_ready;
  assign pop_s      = xfer_s & last_s;

  difftest_group_fifo #(
    .DW (GW),
    .AW (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req_s),
    .pop   (pop_s),
    .din   (grp_in_s),
    .dout  (grp_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Occupancy after this edge, used to decide the stall request.
  always_comb begin
    count_next_s = fifo_count_s;
    if (push_ok_s && !pop_s) begin
      count_next_s = fifo_count_s + {{AW{1'b0}}, 1'b1};
    end else if (pop_s && !push_ok_s) begin
      count_next_s = fifo_count_s - {{AW{1'b0}}, 1'b1};
    end else begin
      count_next_s = fifo_count_s;
    end
    free_next_s = (AW+1)'(FD) - count_next_s;
  end

  // A fresh head group (first_r) uses its own fire bits as the remaining mask.
  always_comb begin
    eff_mask_s = '0;
    if (fifo_empty_s) begin
      eff_mask_s = '0;
    end else if (first_r) begin
      eff_mask_s = h_fire_s;
    end else begin
      eff_mask_s = mask_r;
    end
  end

  // Priority encoder: lowest remaining slot goes first.
  always_comb begin
    sel_idx_s    = '0;
    insn_valid_s = 1'b0;
    for (int i = 0; i < CW; i++) begin
      if (!insn_valid_s && eff_mask_s[i]) begin
        sel_idx_s    = SW'(i);
        insn_valid_s = 1'b1;
      end
    end
    sel_onehot_s = insn_valid_s ? (CW'(1) << sel_idx_s) : '0;
    remain_s     = eff_mask_s & ~sel_onehot_s;
    last_s       = (remain_s == '0);
  end

  // Record fields; exception data rides only on the group's first record.
  always_comb begin
    out_insn_valid = insn_valid_s;
    out_pc         = '0;
    out_insn       = '0;
    out_wen        = 1'b0;
    out_wnum       = '0;
    out_wdata      = '0;
    out_excp       = 1'b0;
    out_excp_vect  = '0;
    out_irqc_irr   = '0;
    if (insn_valid_s) begin
      out_pc    = h_pc_s[sel_idx_s*PC_W +: PC_W];
      out_insn  = h_insn_s[sel_idx_s*NCPU_INSN_DW +: NCPU_INSN_DW];
      out_wen   = h_wen_s[sel_idx_s];
      out_wnum  = h_wnum_s[sel_idx_s*NCPU_LRF_AW +: NCPU_LRF_AW];
      out_wdata = h_wdata_s[sel_idx_s*CONFIG_DW +: CONFIG_DW];
    end else begin
      out_pc    = '0;
    end
    if (!fifo_empty_s && first_r) begin
      out_excp      = h_excp_s;
      out_excp_vect = h_vect_s;
      out_irqc_irr  = h_irr_s;
    end else begin
      out_excp      = 1'b0;
    end
  end

  // Head-group progress, sequence count, stall request and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r  <= '0;
      first_r <= 1'b1;
      seq_r   <= '0;
      stall_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (xfer_s) begin
        if (last_s) begin
          mask_r  <= '0;
          first_r <= 1'b1;
        end else begin
          mask_r  <= remain_s;
          first_r <= 1'b0;
        end
        if (insn_valid_s) begin
          seq_r <= seq_r + 32'd1;
        end
      end
      if (push_req_s && fifo_full_s) begin
        ovf_r <= 1'b1;
      end
      stall_r <= (free_next_s <= (AW+1)'(STALL_MARGIN));
    end
  end

  assign out_seq   = seq_r;
  assign cmt_stall = stall_r;
  assign ovf_err   = ovf_r;

endmodule

// File: tb/tb_difftest_commit_serializer.sv
// Randomized and directed checks of the commit serializer against a
// record-queue reference model (CW=2, FD=8, STALL_MARGIN=2).
module tb_difftest_commit_serializer;
  import difftest_commit_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_fire;
  logic [59:0] in_pc;
  logic [63:0] in_insn;
  logic [1:0]  in_wen;
  logic [9:0]  in_wnum;
  logic [63:0] in_wdata;
  logic        in_excp;
  logic [31:0] in_excp_vect;
  logic [31:0] in_irqc_irr;
  logic        cmt_stall, out_valid, out_ready, out_insn_valid;
  logic [29:0] out_pc;
  logic [31:0] out_insn;
  logic        out_wen;
  logic [4:0]  out_wnum;
  logic [31:0] out_wdata;
  logic        out_excp;
  logic [31:0] out_excp_vect, out_irqc_irr, out_seq;
  logic        ovf_err;

  typedef struct packed {
    logic        iv;
    logic [29:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        excp;
    logic [31:0] vect;
    logic [31:0] irr;
    logic [31:0] seq;
  } rec_t;

  rec_t q[$];
  int   exp_seq;
  int   checks = 0;
  int   errors = 0;

  difftest_commit_serializer dut (
    .clk(clk), .rst(rst), .in_fire(in_fire), .in_pc(in_pc), .in_insn(in_insn),
    .in_wen(in_wen), .in_wnum(in_wnum), .in_wdata(in_wdata), .in_excp(in_excp),
    .in_excp_vect(in_excp_vect), .in_irqc_irr(in_irqc_irr), .cmt_stall(cmt_stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn_valid(out_insn_valid),
    .out_pc(out_pc), .out_insn(out_insn), .out_wen(out_wen), .out_wnum(out_wnum),
    .out_wdata(out_wdata), .out_excp(out_excp), .out_excp_vect(out_excp_vect),
    .out_irqc_irr(out_irqc_irr), .out_seq(out_seq), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic rec_t cap();
    rec_t r;
    r = '{iv: out_insn_valid, pc: out_pc, insn: out_insn, wen: out_wen, wnum: out_wnum,
          wdata: out_wdata, excp: out_excp, vect: out_excp_vect, irr: out_irqc_irr,
          seq: out_seq};
    return r;
  endfunction

  // Next expected record: queue front plus the running instruction count.
  function automatic rec_t model_pop();
    rec_t r;
    if (q.size() == 0) begin
      r = '0;
      r.seq = 32'hFFFF_FFFF;
      return r;
    end
    r = q.pop_front();
    r.seq = exp_seq;
    if (r.iv) exp_seq++;
    return r;
  endfunction

  task automatic clear_in();
    in_fire = 2'b00; in_excp = 1'b0; in_excp_vect = 32'h0; in_irqc_irr = 32'h0;
    in_pc = 60'h0; in_insn = 64'h0; in_wen = 2'b00; in_wnum = 10'h0; in_wdata = 64'h0;
  endtask

  task automatic set_group(input logic [1:0] fire, input logic [59:0] pc, input logic [63:0] insn,
                           input logic [1:0] wen, input logic [9:0] wnum, input logic [63:0] wdata,
                           input logic excp, input logic [31:0] vect, input logic [31:0] irr,
                           input bit model_en);
    rec_t r;
    bit first;
    in_fire = fire; in_pc = pc; in_insn = insn; in_wen = wen; in_wnum = wnum;
    in_wdata = wdata; in_excp = excp; in_excp_vect = vect; in_irqc_irr = irr;
    if (model_en) begin
      first = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (fire[i]) begin
          r = '{iv: 1'b1, pc: pc[i*30 +: 30], insn: insn[i*32 +: 32], wen: wen[i],
                wnum: wnum[i*5 +: 5], wdata: wdata[i*32 +: 32],
                excp: first ? excp : 1'b0, vect: first ? vect : 32'h0,
                irr: first ? irr : 32'h0, seq: 32'h0};
          q.push_back(r);
          first = 1'b0;
        end
      end
      if (fire == 2'b00 && excp) begin
        r = '0;
        r.excp = 1'b1; r.vect = vect; r.irr = irr;
        q.push_back(r);
      end
    end
  endtask

  task automatic rand_group(output bit pushed);
    logic [1:0] f;
    logic e;
    f = 2'($urandom_range(0, 3));
    e = ($urandom_range(0, 7) == 0);
    set_group(f, {30'($urandom), 30'($urandom)}, {$urandom, $urandom}, 2'($urandom),
              10'($urandom), {$urandom, $urandom}, e, e ? $urandom : 32'h0, $urandom, 1'b1);
    pushed = (f != 2'b00) || e;
  endtask

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b0; clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_seq = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (cmt_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", cmt_stall); end
    if (out_seq !== 32'h0) begin errors++; $display("FAIL reset_seq got=%0d exp=0", out_seq); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
  endtask

  task automatic test_pair();
    rec_t g, e;
    do_reset();
    out_ready = 1'b1;
    set_group(2'b11, {30'h101, 30'h100}, {32'hB, 32'hA}, 2'b11, {5'd2, 5'd1},
              {32'h22, 32'h11}, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_latency got=%b exp=0", out_valid); end
    @(negedge clk); clear_in();
    g = cap(); e = model_pop(); checks += 2;
    if (out_valid !== 1'b1 || g.pc !== 30'h100 || g.seq !== 32'd0) begin
      errors++; $display("FAIL pair_rec0 valid=%b pc=%h seq=%0d exp pc=100 seq=0", out_valid, g.pc, g.seq);
    end
    if (g !== e) begin errors++; $display("FAIL pair_model0 got=%h exp=%h", g, e); end
    @(negedge clk);
    g = cap(); e = model_pop(); checks += 2;
    if (out_valid !== 1'b1 || g.pc !== 30'h101 || g.seq !== 32'd1) begin
      errors++; $display("FAIL pair_rec1 valid=%b pc=%h seq=%0d exp pc=101 seq=1", out_valid, g.pc, g.seq);
    end
    if (g !== e) begin errors++; $display("FAIL pair_model1 got=%h exp=%h", g, e); end
    @(negedge clk); checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_excp_slot();
    rec_t g;
    do_reset();
    out_ready = 1'b1;
    set_group(2'b10, {30'h3C0, 30'h3BF}, {32'h1234, 32'h5678}, 2'b10, {5'd7, 5'd3},
              {32'hCAFE, 32'hBEEF}, 1'b1, 32'h80, 32'h5, 1'b1);
    @(negedge clk); clear_in();
    g = cap(); checks++;
    if (!(out_valid === 1'b1 && g.iv === 1'b1 && g.pc === 30'h3C0 && g.excp === 1'b1 &&
          g.vect === 32'h80 && g.irr === 32'h5 && g.seq === 32'd0 && g.wnum === 5'd7)) begin
      errors++; $display("FAIL excp_slot got=%h exp pc=3c0 excp=1 vect=80 irr=5 seq=0", g);
    end
    @(negedge clk); checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL excp_slot_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_excp_only();
    rec_t g, e;
    do_reset();
    out_ready = 1'b1;
    set_group(2'b01, {30'h0, 30'h40}, 64'h1, 2'b01, 10'd1, 64'h9, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    set_group(2'b00, 60'hFFF, 64'hFF, 2'b11, 10'h3FF, 64'hFF, 1'b1, 32'h44, 32'h7, 1'b1);
    g = cap(); e = model_pop(); checks++;
    if (g !== e) begin errors++; $display("FAIL eonly_pre got=%h exp=%h", g, e); end
    @(negedge clk);
    set_group(2'b01, {30'h0, 30'h41}, 64'h2, 2'b01, 10'd2, 64'h8, 1'b0, 32'h0, 32'h0, 1'b1);
    g = cap(); e = model_pop(); checks += 2;
    if (!(g.iv === 1'b0 && g.excp === 1'b1 && g.pc === 30'h0 && g.insn === 32'h0 &&
          g.wen === 1'b0 && g.wdata === 32'h0 && g.vect === 32'h44 && g.seq === 32'd1)) begin
      errors++; $display("FAIL eonly_rec got=%h exp iv=0 excp=1 vect=44 seq=1 fields=0", g);
    end
    if (g !== e) begin errors++; $display("FAIL eonly_model got=%h exp=%h", g, e); end
    @(negedge clk); clear_in();
    g = cap(); checks++;
    if (!(g.iv === 1'b1 && g.pc === 30'h41 && g.seq === 32'd1 && g.excp === 1'b0)) begin
      errors++; $display("FAIL eonly_seq_hold got=%h exp pc=41 seq=1", g);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_ovf();
    rec_t g, e;
    int n;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      set_group(2'b11, {30'(32'h201 + 2*k), 30'(32'h200 + 2*k)}, {32'(k), 32'(k)}, 2'b11,
                {5'(k), 5'(k)}, {32'(k), 32'(k)}, 1'b0, 32'h0, 32'($urandom), 1'b1);
      @(negedge clk); checks++;
      if (cmt_stall !== (k >= 6)) begin
        errors++; $display("FAIL stall_push%0d got=%b exp=%b", k, cmt_stall, (k >= 6));
      end
    end
    set_group(2'b11, {30'h3FF, 30'h3FE}, 64'h0, 2'b00, 10'h0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); clear_in(); checks += 2;
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
    if (cmt_stall !== 1'b1) begin errors++; $display("FAIL stall_full got=%b exp=1", cmt_stall); end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && out_valid; c++) begin
      g = cap(); e = model_pop(); checks++; n++;
      if (g !== e) begin errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", n, g, e); end
      @(negedge clk);
    end
    checks += 3;
    if (n !== 16) begin errors++; $display("FAIL ovf_records got=%0d exp=16", n); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
    if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
  endtask

  task automatic test_random();
    rec_t g, e, held;
    bit hold, pushed, held_valid;
    int groups, cyc;
    do_reset();
    hold = 1'b0; held = '0; held_valid = 1'b0; groups = 0;
    for (cyc = 0; cyc < 30000; cyc++) begin
      if (groups >= 1000 && q.size() == 0 && !out_valid) break;
      g = cap();
      if (hold) begin
        checks++;
        if ({out_valid, g} !== {held_valid, held}) begin
          errors++; $display("FAIL rand_stable cyc=%0d got=%h exp=%h", cyc, g, held);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        e = model_pop(); checks++;
        if (g !== e) begin errors++; $display("FAIL rand_rec cyc=%0d got=%h exp=%h", cyc, g, e); end
      end
      hold = out_valid && !out_ready; held = g; held_valid = out_valid;
      if (groups < 1000 && !cmt_stall && $urandom_range(0, 3) != 0) begin
        rand_group(pushed);
        if (pushed) groups++;
      end else begin
        clear_in();
      end
      @(negedge clk);
    end
    checks += 2;
    if (cyc >= 30000) begin errors++; $display("FAIL rand_budget groups=%0d left=%0d", groups, q.size()); end
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL rand_ovf got=%b exp=0", ovf_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_group(2'b11, {30'(k + 1), 30'(k)}, 64'h0, 2'b01, 10'h0, 64'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
    end
    clear_in(); checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    if (cmt_stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%b exp=1", cmt_stall); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; q.delete(); exp_seq = 0; checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    if (out_seq !== 32'h0) begin errors++; $display("FAIL mid_seq got=%0d exp=0", out_seq); end
    if (cmt_stall !== 1'b0) begin errors++; $display("FAIL mid_stall got=%b exp=0", cmt_stall); end
    out_ready = 1'b1;
    @(negedge clk); checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_partial got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_excp_slot();
    test_excp_only();
    test_stall_ovf();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
